// File: rtl/decode_ctrl_pipe_if.sv
// Instruction-in / decoded-bundle-out signal group for decode_ctrl_pipe.
// Both handshakes: a transfer occurs on a rising clk edge where valid && ready; the producer holds valid and payload stable until then.
interface decode_ctrl_pipe_if #(
    parameter int CNT_W = 16
);
    logic             i_valid;
    logic [31:0]      i_Instr;
    logic             o_ready;
    logic             i_flush;

    logic             o_valid;
    logic             i_ready;

    logic             o_Branch;
    logic             o_MemRead;
    logic             o_MemWrite;
    logic             o_MemToReg;
    logic             o_ALUSrcB;
    logic             o_RegWrite;
    logic             o_PCplus4;
    logic             o_CSR_en;
    logic             o_Ex;
    logic             o_atomic;
    logic [2:0]       o_ALUOp;
    logic [1:0]       o_ALUSrcA;
    logic [1:0]       o_Jump;
    logic [31:0]      o_Instr;

    logic [CNT_W-1:0] o_illegal_cnt;
    logic             o_dbg_amo_wr;

    modport master (
        output i_valid, i_Instr, i_flush, i_ready,
        input  o_ready, o_valid,
        input  o_Branch, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrcB, o_RegWrite,
        input  o_PCplus4, o_CSR_en, o_Ex, o_atomic, o_ALUOp, o_ALUSrcA, o_Jump, o_Instr,
        input  o_illegal_cnt, o_dbg_amo_wr
    );

    modport slave (
        input  i_valid, i_Instr, i_flush, i_ready,
        output o_ready, o_valid,
        output o_Branch, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrcB, o_RegWrite,
        output o_PCplus4, o_CSR_en, o_Ex, o_atomic, o_ALUOp, o_ALUSrcA, o_Jump, o_Instr,
        output o_illegal_cnt, o_dbg_amo_wr
    );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// RV32 control decoder feeding a DEPTH-entry bundle FIFO, with a saturating illegal-instruction counter.
// Macro ARVI_ATOMIC_EN adds A-extension decode and the AMO read/write micro-op FSM.
module decode_ctrl_pipe #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic i_clk,
    input logic i_rst,
    decode_ctrl_pipe_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src_b;
        logic        reg_write;
        logic        pc_plus4;
        logic        csr_en;
        logic        ex;
        logic        atomic;
        logic [2:0]  alu_op;
        logic [1:0]  alu_src_a;
        logic [1:0]  jump;
        logic [31:0] instr;
    } bundle_t;

`ifdef ARVI_ATOMIC_EN
    localparam logic       ATOMIC_EN = 1'b1;
    localparam logic [6:0] OP_AMO    = 7'b0101111;
    localparam logic [4:0] F5_LR     = 5'b00010;
    localparam logic [4:0] F5_SC     = 5'b00011;
`else
    localparam logic       ATOMIC_EN = 1'b0;
`endif

    function automatic bundle_t decode(input logic [31:0] instr);
        bundle_t b;
        b       = '0;
        b.instr = instr;
        case (instr[6:0])
            OP_R: begin
                b.reg_write = 1'b1;
                b.alu_op    = 3'b010;
            end
            OP_IMM: begin
                b.alu_src_b = 1'b1;
                b.reg_write = 1'b1;
                b.alu_op    = 3'b011;
            end
            OP_LOAD: begin
                b.mem_read   = 1'b1;
                b.mem_to_reg = 1'b1;
                b.alu_src_b  = 1'b1;
                b.reg_write  = 1'b1;
            end
            OP_STORE: begin
                b.mem_write = 1'b1;
                b.alu_src_b = 1'b1;
            end
            OP_BRANCH: begin
                b.branch = 1'b1;
                b.alu_op = 3'b001;
            end
            OP_LUI: begin
                b.alu_src_a = 2'd2;
                b.alu_src_b = 1'b1;
                b.reg_write = 1'b1;
                b.alu_op    = 3'b100;
            end
            OP_AUIPC: begin
                b.alu_src_a = 2'd1;
                b.alu_src_b = 1'b1;
                b.reg_write = 1'b1;
                b.alu_op    = 3'b100;
            end
            OP_JAL: begin
                b.reg_write = 1'b1;
                b.jump      = 2'd1;
                b.pc_plus4  = 1'b1;
            end
            OP_JALR: begin
                b.alu_src_b = 1'b1;
                b.reg_write = 1'b1;
                b.alu_op    = 3'b100;
                b.jump      = 2'd2;
                b.pc_plus4  = 1'b1;
            end
            OP_FENCE: begin
                b.instr = instr;
            end
            OP_SYSTEM: begin
                // ecall/ebreak (imm 0/1 with zero f3, rs1, rd) trap; CSR ops do not
                b.reg_write = 1'b1;
                b.csr_en    = 1'b1;
                b.ex        = (instr[14:12] == 3'b000) && (instr[19:15] == 5'd0) &&
                              (instr[11:7] == 5'd0) && (instr[31:21] == 11'd0);
            end
`ifdef ARVI_ATOMIC_EN
            OP_AMO: begin
                b.mem_read   = 1'b1;
                b.mem_to_reg = 1'b1;
                b.reg_write  = 1'b1;
                b.atomic     = 1'b1;
                if (instr[31:27] == F5_LR) begin
                    b.alu_op = 3'b101;
                end else if (instr[31:27] == F5_SC) begin
                    b.alu_op    = 3'b101;
                    b.mem_write = 1'b1;
                end
            end
`endif
            default: begin
                b.ex = 1'b1;
            end
        endcase
        return b;
    endfunction

    bundle_t           mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    occ_q, occ_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    bundle_t dec_b;
    bundle_t push_b;
    bundle_t out_b;
    logic    full;
    logic    idle;
    logic    ready;
    logic    accept;
    logic    pop;
    logic    push;
    logic    amo_push;
    bundle_t amo_wr_b;

    assign full   = (occ_q == OCC_FULL);
    assign ready  = !full && idle && !bus.i_flush;
    assign accept = bus.i_valid && ready;
    assign pop    = bus.o_valid && bus.i_ready && !bus.i_flush;
    assign dec_b  = decode(bus.i_Instr);
    assign push   = accept || amo_push;
    assign push_b = amo_push ? amo_wr_b : dec_b;

`ifdef ARVI_ATOMIC_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_AMO_WR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] amo_instr_q;
    logic        accept_amo;

    assign accept_amo = accept && (bus.i_Instr[6:0] == OP_AMO) &&
                        (bus.i_Instr[31:27] != F5_LR) && (bus.i_Instr[31:27] != F5_SC);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            amo_instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_amo) begin
                amo_instr_q <= bus.i_Instr;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        amo_push = 1'b0;
        if (bus.i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_amo) begin
                        state_d = ST_AMO_WR;
                    end
                end
                ST_AMO_WR: begin
                    // Write half waits for a free slot; occupancy before any pop decides
                    if (!full) begin
                        amo_push = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        amo_wr_b           = '0;
        amo_wr_b.mem_write = 1'b1;
        amo_wr_b.atomic    = 1'b1;
        amo_wr_b.alu_op    = 3'b101;
        amo_wr_b.instr     = amo_instr_q;
    end

    assign idle             = (state_q == ST_IDLE);
    assign bus.o_dbg_amo_wr = (state_q == ST_AMO_WR);
`else
    assign amo_push         = 1'b0;
    assign amo_wr_b         = '0;
    assign idle             = 1'b1;
    assign bus.o_dbg_amo_wr = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                occ_d = occ_q + (PTR_W + 1)'(1);
            end else if (!push && pop) begin
                occ_d = occ_q - (PTR_W + 1)'(1);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && dec_b.ex && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_b;
        end
    end

    // Storage is not reset; gating with o_valid keeps the bundle at zero whenever the FIFO is empty
    assign bus.o_valid = (occ_q != '0);
    assign out_b       = bus.o_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.o_ready = ready;

    assign bus.o_Branch      = out_b.branch;
    assign bus.o_MemRead     = out_b.mem_read;
    assign bus.o_MemWrite    = out_b.mem_write;
    assign bus.o_MemToReg    = out_b.mem_to_reg;
    assign bus.o_ALUSrcB     = out_b.alu_src_b;
    assign bus.o_RegWrite    = out_b.reg_write;
    assign bus.o_PCplus4     = out_b.pc_plus4;
    assign bus.o_CSR_en      = out_b.csr_en;
    assign bus.o_Ex          = out_b.ex;
    assign bus.o_atomic      = out_b.atomic & ATOMIC_EN;
    assign bus.o_ALUOp       = out_b.alu_op;
    assign bus.o_ALUSrcA     = out_b.alu_src_a;
    assign bus.o_Jump        = out_b.jump;
    assign bus.o_Instr       = out_b.instr;
    assign bus.o_illegal_cnt = cnt_q;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe: directed scenarios plus a randomized run against a queue-based model.
// Build with or without +define+ARVI_ATOMIC_EN; expectations follow the same macro.
module tb_decode_ctrl_pipe;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        br, mr, mw, m2r, asb, rw, pc4, csr, ex, at;
        logic [2:0]  aop;
        logic [1:0]  asa;
        logic [1:0]  jmp;
        logic [31:0] ins;
    } bun_t;

    localparam int W = $bits(bun_t);

    localparam logic [6:0] OPS [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                        7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                        7'b1100111, 7'b0001111, 7'b1110011, 7'b0101111};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_ctrl_pipe_if #(.CNT_W(CNT_W)) bus ();
    decode_ctrl_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model state ----------------
    logic [W-1:0] exp_q[$];
    logic         m_amo_pend;
    logic [31:0]  m_amo_ins;
    int           m_cnt;

    function automatic logic is_amo(input logic [31:0] ins);
`ifdef ARVI_ATOMIC_EN
        return (ins[6:0] == 7'b0101111) && (ins[31:27] != 5'b00010) && (ins[31:27] != 5'b00011);
`else
        return (ins == 32'hFFFF_FFFF) && (ins != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic bun_t ref_decode(input logic [31:0] ins);
        bun_t b;
        b     = '0;
        b.ins = ins;
        case (ins[6:0])
            7'b0110011: begin b.rw = 1'b1; b.aop = 3'b010; end
            7'b0010011: begin b.asb = 1'b1; b.rw = 1'b1; b.aop = 3'b011; end
            7'b0000011: begin b.mr = 1'b1; b.m2r = 1'b1; b.asb = 1'b1; b.rw = 1'b1; end
            7'b0100011: begin b.mw = 1'b1; b.asb = 1'b1; end
            7'b1100011: begin b.br = 1'b1; b.aop = 3'b001; end
            7'b0110111: begin b.asa = 2'd2; b.asb = 1'b1; b.rw = 1'b1; b.aop = 3'b100; end
            7'b0010111: begin b.asa = 2'd1; b.asb = 1'b1; b.rw = 1'b1; b.aop = 3'b100; end
            7'b1101111: begin b.rw = 1'b1; b.jmp = 2'd1; b.pc4 = 1'b1; end
            7'b1100111: begin b.asb = 1'b1; b.rw = 1'b1; b.aop = 3'b100; b.jmp = 2'd2; b.pc4 = 1'b1; end
            7'b0001111: b.ins = ins;
            7'b1110011: begin
                b.rw  = 1'b1;
                b.csr = 1'b1;
                b.ex  = (ins[14:12] == 3'd0) && (ins[19:15] == 5'd0) && (ins[11:7] == 5'd0) &&
                        ((ins[31:20] == 12'd0) || (ins[31:20] == 12'd1));
            end
`ifdef ARVI_ATOMIC_EN
            7'b0101111: begin
                b.mr = 1'b1; b.m2r = 1'b1; b.rw = 1'b1; b.at = 1'b1;
                if (ins[31:27] == 5'b00010) b.aop = 3'b101;
                if (ins[31:27] == 5'b00011) begin b.aop = 3'b101; b.mw = 1'b1; end
            end
`endif
            default: b.ex = 1'b1;
        endcase
        return b;
    endfunction

    function automatic bun_t ref_amo_wr(input logic [31:0] ins);
        bun_t b;
        b     = '0;
        b.mw  = 1'b1;
        b.at  = 1'b1;
        b.aop = 3'b101;
        b.ins = ins;
        return b;
    endfunction

    function automatic logic m_ready(input logic fl);
        return (exp_q.size() < DEPTH) && !m_amo_pend && !fl;
    endfunction

    // Advance the model across one rising edge with the inputs presented this cycle.
    task automatic model_step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        logic acc, pop, wr;
        bun_t b;
        acc = v && m_ready(fl);
        pop = (exp_q.size() != 0) && rdy;
        wr  = m_amo_pend && (exp_q.size() < DEPTH);
        if (fl) begin
            exp_q.delete();
            m_amo_pend = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                b = ref_decode(ins);
                exp_q.push_back(b);
                if (b.ex && m_cnt < CNT_MAX) m_cnt++;
                if (is_amo(ins)) begin
                    m_amo_pend = 1'b1;
                    m_amo_ins  = ins;
                end
            end
            if (wr) begin
                exp_q.push_back(ref_amo_wr(m_amo_ins));
                m_amo_pend = 1'b0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        bus.i_valid = v;
        bus.i_Instr = ins;
        bus.i_ready = rdy;
        bus.i_flush = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_amo_pend = 1'b0;
        m_amo_ins  = '0;
        m_cnt      = 0;
    endtask

    function automatic bun_t dut_bundle();
        bun_t b;
        b.br  = bus.o_Branch;   b.mr  = bus.o_MemRead;  b.mw  = bus.o_MemWrite;
        b.m2r = bus.o_MemToReg; b.asb = bus.o_ALUSrcB;  b.rw  = bus.o_RegWrite;
        b.pc4 = bus.o_PCplus4;  b.csr = bus.o_CSR_en;   b.ex  = bus.o_Ex;
        b.at  = bus.o_atomic;   b.aop = bus.o_ALUOp;    b.asa = bus.o_ALUSrcA;
        b.jmp = bus.o_Jump;     b.ins = bus.o_Instr;
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int k, s;
        ins = $urandom;
        k   = $urandom_range(0, 12);
        if (k < 12) ins[6:0] = OPS[k];
        if (ins[6:0] == 7'b1110011 && $urandom_range(0, 1) == 1) begin
            ins[31:7]  = '0;
            ins[21:20] = 2'($urandom_range(0, 3));
        end
        if (ins[6:0] == 7'b0101111) begin
            s = $urandom_range(0, 2);
            if (s == 0) ins[31:27] = 5'b00010;
            if (s == 1) ins[31:27] = 5'b00011;
        end
        return ins;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus.o_valid); end
        n_tests++; if (bus.o_illegal_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", bus.o_illegal_cnt); end
        n_tests++; if (dut_bundle() !== bun_t'('0)) begin n_fail++; $display("FAIL reset_bundle: got %h exp 0", dut_bundle()); end
        do_reset();
        @(negedge clk);
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", bus.o_ready); end
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_after: got %b exp 0", bus.o_valid); end
        // Asynchronous reset mid-stream (and mid-AMO when atomics are enabled)
        @(posedge clk); #1;
        drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'h00C5A52F, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b exp 0", bus.o_valid); end
        n_tests++; if (bus.o_illegal_cnt !== 2'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d exp 0", bus.o_illegal_cnt); end
        n_tests++; if (bus.o_dbg_amo_wr !== 1'b0) begin n_fail++; $display("FAIL async_rst_fsm: got %b exp 0", bus.o_dbg_amo_wr); end
        @(posedge clk); #1 rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard_amo[%0d]: got valid %b exp 0", i, bus.o_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
        bun_t e;
        do_reset();
        drive(1'b1, 32'h00500093, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready: got %b exp 1", bus.o_ready); end
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL addi_valid_c0: got %b exp 0", bus.o_valid); end
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        e = '0; e.asb = 1'b1; e.rw = 1'b1; e.aop = 3'b011; e.ins = 32'h00500093;
        n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid_c1: got %b exp 1", bus.o_valid); end
        n_tests++; if (dut_bundle() !== e) begin n_fail++; $display("FAIL addi_bundle: got %h exp %h", dut_bundle(), e); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drained: got %b exp 0", bus.o_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [5];
        do_reset();
        for (int i = 0; i < 5; i++) ins[i] = 32'h00000093 | (32'(i + 1) << 20);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ins[i], 1'b0, 1'b0);
            @(negedge clk);
            n_tests++; if (bus.o_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b exp %b", i, bus.o_ready, (i < 4)); end
            if (i > 0) begin
                n_tests++; if (bus.o_Instr !== ins[0]) begin n_fail++; $display("FAIL bp_head_stable[%0d]: got %h exp %h", i, bus.o_Instr, ins[0]); end
            end
            @(posedge clk); #1;
        end
        // A pop in the same cycle does not reopen o_ready
        drive(1'b1, ins[4], 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_on_pop: got %b exp 0", bus.o_ready); end
        n_tests++; if (bus.o_Instr !== ins[0]) begin n_fail++; $display("FAIL bp_drain[0]: got %h exp %h", bus.o_Instr, ins[0]); end
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            n_tests++; if (bus.o_valid !== 1'b1 || bus.o_Instr !== ins[i]) begin n_fail++; $display("FAIL bp_drain[%0d]: got %b/%h exp 1/%h", i, bus.o_valid, bus.o_Instr, ins[i]); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b exp 0", bus.o_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1'b1, 32'h00000073, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'h30529073, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if ({bus.o_Ex, bus.o_CSR_en, bus.o_RegWrite} !== 3'b111) begin n_fail++; $display("FAIL ecall_fields: got %b exp 111", {bus.o_Ex, bus.o_CSR_en, bus.o_RegWrite}); end
        n_tests++; if (bus.o_illegal_cnt !== 2'd1) begin n_fail++; $display("FAIL ecall_cnt: got %0d exp 1", bus.o_illegal_cnt); end
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if ({bus.o_Ex, bus.o_CSR_en} !== 2'b01) begin n_fail++; $display("FAIL csrrw_fields: got %b exp 01", {bus.o_Ex, bus.o_CSR_en}); end
        n_tests++; if (bus.o_illegal_cnt !== 2'd1) begin n_fail++; $display("FAIL csrrw_cnt: got %0d exp 1", bus.o_illegal_cnt); end
        @(posedge clk); #1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h0000007F, 1'b1, 1'b0);
            @(posedge clk); #1;
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            @(negedge clk);
            n_tests++; if (bus.o_illegal_cnt !== CNT_W'((k + 1 > CNT_MAX) ? CNT_MAX : k + 1)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", k, bus.o_illegal_cnt, (k + 1 > CNT_MAX) ? CNT_MAX : k + 1); end
            n_tests++; if (bus.o_Ex !== 1'b1 || bus.o_RegWrite !== 1'b0) begin n_fail++; $display("FAIL illegal_bundle[%0d]: got ex %b rw %b exp 1 0", k, bus.o_Ex, bus.o_RegWrite); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_atomic();
        bun_t e;
        do_reset();
        drive(1'b1, 32'h00C5A52F, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL amo_accept_ready: got %b exp 1", bus.o_ready); end
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
`ifdef ARVI_ATOMIC_EN
        e = '0; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; e.at = 1'b1; e.ins = 32'h00C5A52F;
        n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL amo_wr_ready: got %b exp 0", bus.o_ready); end
        n_tests++; if (bus.o_dbg_amo_wr !== 1'b1) begin n_fail++; $display("FAIL amo_wr_state: got %b exp 1", bus.o_dbg_amo_wr); end
        n_tests++; if (dut_bundle() !== e) begin n_fail++; $display("FAIL amo_read_uop: got %h exp %h", dut_bundle(), e); end
        @(posedge clk); #1;
        @(negedge clk);
        e = '0; e.mw = 1'b1; e.at = 1'b1; e.aop = 3'b101; e.ins = 32'h00C5A52F;
        n_tests++; if (bus.o_valid !== 1'b1 || dut_bundle() !== e) begin n_fail++; $display("FAIL amo_write_uop: got %b/%h exp 1/%h", bus.o_valid, dut_bundle(), e); end
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL amo_ready_back: got %b exp 1", bus.o_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL amo_two_only: got %b exp 0", bus.o_valid); end
`else
        e = '0; e.ex = 1'b1; e.ins = 32'h00C5A52F;
        n_tests++; if (dut_bundle() !== e) begin n_fail++; $display("FAIL amo_illegal: got %h exp %h", dut_bundle(), e); end
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL amo_ready: got %b exp 1", bus.o_ready); end
        n_tests++; if (bus.o_illegal_cnt !== 2'd1) begin n_fail++; $display("FAIL amo_cnt: got %0d exp 1", bus.o_illegal_cnt); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL amo_one_only: got %b exp 0", bus.o_valid); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'h00A00113, 1'b0, 1'b0);
        @(posedge clk); #1;
`ifdef ARVI_ATOMIC_EN
        drive(1'b1, 32'h00C5A52F, 1'b0, 1'b0);
`else
        drive(1'b1, 32'h00B00193, 1'b0, 1'b0);
`endif
        @(posedge clk); #1;
        drive(1'b1, 32'h00C00213, 1'b1, 1'b1);
        @(negedge clk);
        n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_during: got %b exp 0", bus.o_ready); end
        n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b exp 1", bus.o_valid); end
`ifdef ARVI_ATOMIC_EN
        n_tests++; if (bus.o_dbg_amo_wr !== 1'b1) begin n_fail++; $display("FAIL flush_pre_state: got %b exp 1", bus.o_dbg_amo_wr); end
`endif
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", bus.o_valid); end
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b exp 1", bus.o_ready); end
        n_tests++; if (bus.o_dbg_amo_wr !== 1'b0) begin n_fail++; $display("FAIL flush_state: got %b exp 0", bus.o_dbg_amo_wr); end
        n_tests++; if (bus.o_illegal_cnt !== 2'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d exp 1", bus.o_illegal_cnt); end
        @(posedge clk); #1;
        drive(1'b1, 32'h00D002B3, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (bus.o_valid !== 1'b1 || bus.o_Instr !== 32'h00D002B3) begin n_fail++; $display("FAIL flush_restart: got %b/%h exp 1/00d002b3", bus.o_valid, bus.o_Instr); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic v, rdy, fl;
        logic [31:0] ins;
        logic [W-1:0] got;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            ins = rand_instr();
            drive(v, ins, rdy, fl);
            @(negedge clk);
            n_tests++; if (bus.o_ready !== m_ready(fl)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, bus.o_ready, m_ready(fl)); end
            n_tests++; if (bus.o_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b exp %b", c, bus.o_valid, (exp_q.size() != 0)); end
            if (exp_q.size() != 0) begin
                got = dut_bundle();
                n_tests++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL rnd_bundle c%0d: got %h exp %h", c, got, exp_q[0]); end
            end
            n_tests++; if (bus.o_illegal_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d exp %0d", c, bus.o_illegal_cnt, m_cnt); end
`ifdef ARVI_ATOMIC_EN
            n_tests++; if (bus.o_dbg_amo_wr !== m_amo_pend) begin n_fail++; $display("FAIL rnd_state c%0d: got %b exp %b", c, bus.o_dbg_amo_wr, m_amo_pend); end
`endif
            model_step(v, ins, rdy, fl);
            @(posedge clk); #1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_atomic();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, exp completion");
        $fatal(1, "timeout");
    end
endmodule
